i2c_arbiter: RTL

I2C_ARBITER -- requirements
Module: i2c_arbiter

---
 rtl/i2c_arbiter_if.sv | 28 ++
 rtl/i2c_arbiter.sv | 114 +++++++++++
 2 files changed

// File: rtl/i2c_arbiter_if.sv
// Bundle of requester-side and I2C-master-side signals for i2c_arbiter.
// The arbiter uses the master modport; a requester/I2C-master model uses slave.
interface i2c_arbiter_if;
    logic [1:0]  REQ;
    logic [1:0]  RNW;
    logic [13:0] ADDR;
    logic [31:0] WDATA;
    logic [1:0]  GNT;
    logic [1:0]  DONE;
    logic        ERR;
    logic [15:0] RDATA;
    logic        START_STB;
    logic [6:0]  I2C_ADDR;
    logic        I2C_RNW;
    logic [15:0] I2C_WDATA;
    logic        I2C_BUSY;
    logic [15:0] I2C_RD_DATA;

    modport master (
        input  REQ, RNW, ADDR, WDATA, I2C_BUSY, I2C_RD_DATA,
        output GNT, DONE, ERR, RDATA, START_STB, I2C_ADDR, I2C_RNW, I2C_WDATA
    );

    modport slave (
        output REQ, RNW, ADDR, WDATA, I2C_BUSY, I2C_RD_DATA,
        input  GNT, DONE, ERR, RDATA, START_STB, I2C_ADDR, I2C_RNW, I2C_WDATA
    );
endinterface

// File: rtl/i2c_arbiter.sv
// Two-requester round-robin arbiter in front of a single I2C master, with
// start-to-busy and start-to-idle timeouts reported through ERR on DONE.
module i2c_arbiter #(
    parameter int unsigned TIMEOUT_CYC   = 4096,
    parameter int unsigned BUSY_WAIT_CYC = 16
) (
    input logic           clk,
    input logic           RESET,
    i2c_arbiter_if.master bus
);
    localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);
    // Counter holds completed wait cycles, so the limit fires one below the budget.
    localparam logic [CW-1:0] BW_LIM = CW'(BUSY_WAIT_CYC - 1);
    localparam logic [CW-1:0] TO_LIM = CW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        IDLE, GRANT, START, WAIT_BUSY, WAIT_IDLE, FINISH
    } state_t;

    state_t          r_state, w_next;
    logic            r_sel, r_last, r_err, r_rnw;
    logic [CW-1:0]   r_cnt;
    logic [15:0]     r_rdata, r_wdata;
    logic [6:0]      r_addr;
    logic            w_sel, w_set_err, w_capture, w_stb;
    logic [1:0]      w_gnt, w_done;

    always_comb begin
        w_next    = r_state;
        w_set_err = 1'b0;
        w_capture = 1'b0;
        w_gnt     = '0;
        w_done    = '0;
        w_stb     = 1'b0;
        if (bus.REQ == 2'b01)      w_sel = 1'b0;
        else if (bus.REQ == 2'b10) w_sel = 1'b1;
        else                       w_sel = ~r_last;
        case (r_state)
            IDLE:      if (bus.REQ != 2'b00) w_next = GRANT;
            GRANT: begin
                w_gnt  = r_sel ? 2'b10 : 2'b01;
                w_next = START;
            end
            START: begin
                w_stb  = 1'b1;
                w_next = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (bus.I2C_BUSY) begin
                    w_next = WAIT_IDLE;
                end else if (r_cnt >= BW_LIM) begin
                    w_next    = FINISH;
                    w_set_err = 1'b1;
                end
            end
            // BUSY low wins over a coincident timeout.
            WAIT_IDLE: begin
                if (!bus.I2C_BUSY) begin
                    w_next    = FINISH;
                    w_capture = 1'b1;
                end else if (r_cnt >= TO_LIM) begin
                    w_next    = FINISH;
                    w_set_err = 1'b1;
                end
            end
            FINISH: begin
                w_done = r_sel ? 2'b10 : 2'b01;
                w_next = IDLE;
            end
            default:   w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            r_state <= IDLE;
            r_sel   <= 1'b0;
            r_last  <= 1'b1;
            r_err   <= 1'b0;
            r_cnt   <= '0;
            r_rdata <= '0;
            r_addr  <= '0;
            r_rnw   <= 1'b0;
            r_wdata <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_next == GRANT) begin
                r_sel   <= w_sel;
                r_addr  <= w_sel ? bus.ADDR[13:7]   : bus.ADDR[6:0];
                r_rnw   <= bus.RNW[w_sel];
                r_wdata <= w_sel ? bus.WDATA[31:16] : bus.WDATA[15:0];
            end
            if (r_state == START) begin
                r_cnt   <= '0;
                r_err   <= 1'b0;
                r_rdata <= '0;
            end else if ((r_state == WAIT_BUSY || r_state == WAIT_IDLE) && r_cnt != '1) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_set_err) r_err <= 1'b1;
            if (w_capture) r_rdata <= r_rnw ? bus.I2C_RD_DATA : '0;
            if (r_state == FINISH) r_last <= r_sel;
        end
    end

    assign bus.GNT       = w_gnt;
    assign bus.DONE      = w_done;
    assign bus.START_STB = w_stb;
    assign bus.ERR       = r_err;
    assign bus.RDATA     = r_rdata;
    assign bus.I2C_ADDR  = r_addr;
    assign bus.I2C_RNW   = r_rnw;
    assign bus.I2C_WDATA = r_wdata;
endmodule
